commit_trace_buffer: RTL

//  Sits downstream of the CPU retire point and consumes its per-cycle commit signals.

---
 rtl/commit_trace_buffer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Watches the CPU retire point. Each retired instruction is classified as
// REG / LOAD / STORE / OTHER / HALT and written as one 55-bit entry into a
// first-word-fall-through FIFO. The host drains the FIFO over rd_valid/rd_ready.
// Capture freezes on a halting instruction or when MAX_CYCLES running cycles
// have elapsed. Cycle, instruction and drop counters are kept alongside.
//
// Optional feature: define TRACE_FILTER_EN to keep OTHER (branch/NOP) entries
// out of the FIFO. They are still counted in inst_count and cycle_count.
//
// Read handshake: the head entry is offered whenever rd_valid=1 and rd_entry
// holds it steadily. It is consumed on a rising edge where rd_valid & rd_ready.
// rd_ready while empty has no effect. rd_entry reads zero while the FIFO is empty.
//
// state_dbg exposes the FSM state: 0=IDLE 1=RUN 2=HALTED 3=TIMEOUT.
module commit_trace_buffer #(
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] pc,
    input  logic        reg_write,
    input  logic [3:0]  write_reg,
    input  logic [15:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        hlt,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [54:0] rd_entry,
    output logic [31:0] cycle_count,
    output logic [31:0] inst_count,
    output logic [15:0] drop_count,
    output logic        overflow,
    output logic        timeout,
    output logic        done,
    output logic [1:0]  state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE   = 1;
    localparam logic [31:0]  MAX_C     = 32'(MAX_CYCLES);
    localparam logic         LIMIT_ON  = (MAX_CYCLES != 0);

    localparam logic [2:0] T_REG   = 3'd0;
    localparam logic [2:0] T_LOAD  = 3'd1;
    localparam logic [2:0] T_STORE = 3'd2;
    localparam logic [2:0] T_OTHER = 3'd3;
    localparam logic [2:0] T_HALT  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] inst_count_q, inst_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        overflow_q, overflow_d;
    logic        timeout_q, timeout_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    logic [54:0] mem_q [DEPTH];

    logic [2:0]  ev_type;
    logic [3:0]  ev_reg;
    logic [15:0] ev_data;
    logic [15:0] ev_addr;
    logic [54:0] ev_entry;
    logic        ev_keep;

    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        capture;
    logic        push_req;
    logic        push;
    logic        drop;
    logic [31:0] cycle_inc;
    logic        hit_limit;

    // Classify the retiring instruction and zero the fields its type does not use
    always_comb begin
        ev_type = T_OTHER;
        ev_reg  = 4'd0;
        ev_data = 16'd0;
        ev_addr = 16'd0;
        if (hlt) begin
            ev_type = T_HALT;
        end else if (reg_write && mem_read) begin
            ev_type = T_LOAD;
            ev_reg  = write_reg;
            ev_data = write_data;
            ev_addr = mem_addr;
        end else if (reg_write) begin
            ev_type = T_REG;
            ev_reg  = write_reg;
            ev_data = write_data;
        end else if (mem_write) begin
            ev_type = T_STORE;
            ev_data = mem_data;
            ev_addr = mem_addr;
        end
    end

    assign ev_entry = {ev_type, pc, ev_reg, ev_data, ev_addr};

`ifdef TRACE_FILTER_EN
    assign ev_keep = (ev_type != T_OTHER);
`else
    assign ev_keep = 1'b1;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop      = !fifo_empty && rd_ready;
    assign capture  = (state_q == S_RUN) && run;
    assign push_req = capture && ev_keep;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    assign cycle_inc = cycle_count_q + 32'd1;
    assign hit_limit = LIMIT_ON && (cycle_inc == MAX_C);

    // Next-state logic for the FSM, counters, sticky flags and FIFO pointers
    always_comb begin
        state_d       = state_q;
        cycle_count_d = cycle_count_q;
        inst_count_d  = inst_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        timeout_d     = timeout_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                // The cycle that first sees run high only arms capture
                if (run) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else begin
                    cycle_count_d = cycle_inc;
                    inst_count_d  = inst_count_q + 32'd1;
                    // Halt wins over a coincident limit hit, leaving timeout clear
                    if (hlt) begin
                        state_d = S_HALTED;
                    end else if (hit_limit) begin
                        state_d   = S_TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Register all control state; asynchronous reset returns to IDLE and empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cycle_count_q <= 32'd0;
            inst_count_q  <= 32'd0;
            drop_count_q  <= 16'd0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            inst_count_q  <= inst_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only observable through valid pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= ev_entry;
        end
    end

    assign rd_valid    = !fifo_empty;
    assign rd_entry    = fifo_empty ? 55'd0 : mem_q[rd_ptr_q[AW-1:0]];
    assign cycle_count = cycle_count_q;
    assign inst_count  = inst_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;
    assign timeout     = timeout_q;
    assign done        = ((state_q == S_HALTED) || (state_q == S_TIMEOUT)) && fifo_empty;
    assign state_dbg   = state_q;

endmodule
